// File: rtl/cordic_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : cordic_sched_if
// Description : Bundle of requester, result and core-side signals for the
//               cordic_sched round-robin CORDIC scheduler.
//               slave  - scheduler side (drives readies, result, core ops)
//               master - environment side (requesters, consumer, core stub)
// Signals     : req0_*/req1_* : valid/ready job handshake plus x/y operands
//               res_*         : one-entry result register (valid/ready/phi/id)
//               busy          : a job occupies the core
//               core_*        : start pulse, held operands, returned phase
// Revision    : 1.0 - initial release
// ============================================================================
interface cordic_sched_if #(
  parameter int W = 32
) ();
  logic         req0_valid;
  logic         req0_ready;
  logic [W-1:0] req0_x;
  logic [W-1:0] req0_y;
  logic         req1_valid;
  logic         req1_ready;
  logic [W-1:0] req1_x;
  logic [W-1:0] req1_y;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res_phi;
  logic         res_id;
  logic         busy;
  logic         core_start;
  logic [W-1:0] core_x;
  logic [W-1:0] core_y;
  logic [W-1:0] core_phi;

  modport slave (
    input  req0_valid, req0_x, req0_y,
    input  req1_valid, req1_x, req1_y,
    input  res_ready, core_phi,
    output req0_ready, req1_ready,
    output res_valid, res_phi, res_id,
    output busy, core_start, core_x, core_y
  );

  modport master (
    output req0_valid, req0_x, req0_y,
    output req1_valid, req1_x, req1_y,
    output res_ready, core_phi,
    input  req0_ready, req1_ready,
    input  res_valid, res_phi, res_id,
    input  busy, core_start, core_x, core_y
  );
endinterface
`default_nettype wire

// File: rtl/cordic_sched.sv
`default_nettype none
// ============================================================================
// Module      : cordic_sched
// Description : Round-robin scheduler sharing one fixed-latency CORDIC core
//               between two requesters. Latches operands on accept, pulses
//               core_start, counts CORE_LAT cycles, then captures core_phi
//               into a one-entry result register tagged with the requester.
// Ports       : clk     - rising-edge clock
//               rst     - synchronous active-high reset
//               bus     - cordic_sched_if.slave (requesters, result, core)
//               job_cnt - [15:0] saturating count of captured results
//                         (present only with CORDIC_SCHED_STATS_EN defined)
// Options     : CORDIC_SCHED_STATS_EN - adds the job_cnt statistics output
// Revision    : 1.0 - initial release
// ============================================================================
module cordic_sched #(
  parameter int W        = 32,
  parameter int CORE_LAT = 28
) (
  input  logic                 clk,
  input  logic                 rst,
`ifdef CORDIC_SCHED_STATS_EN
  output logic [15:0]          job_cnt,
`endif
  cordic_sched_if.slave        bus
);

  localparam int              CNT_W    = $clog2(CORE_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CORE_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               last_grant_q, last_grant_d;
  logic               id_q, id_d;
  logic [W-1:0]       core_x_q, core_x_d;
  logic [W-1:0]       core_y_q, core_y_d;
  logic               core_start_q, core_start_d;
  logic               res_valid_q, res_valid_d;
  logic [W-1:0]       res_phi_q, res_phi_d;
  logic               res_id_q, res_id_d;

  logic slot_free;
  logic grant0, grant1;
  logic ready0, ready1;
  logic accept0, accept1;
  logic capture;

  // Handshake decode. Readies are forced low while rst is high so a
  // handshake can never coincide with reset.
  always_comb begin
    slot_free = !res_valid_q || bus.res_ready;
    // On contention the requester not granted last wins.
    grant0    = bus.req0_valid && (!bus.req1_valid ||  last_grant_q);
    grant1    = bus.req1_valid && (!bus.req0_valid || !last_grant_q);
    ready0    = !rst && (state_q == ST_IDLE) && slot_free && grant0;
    ready1    = !rst && (state_q == ST_IDLE) && slot_free && grant1;
    accept0   = ready0 && bus.req0_valid;
    accept1   = ready1 && bus.req1_valid;
    capture   = (state_q == ST_RUN) && (cnt_q == CNT_LAST);
  end

  // Next-state and datapath next values.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    core_x_d     = core_x_q;
    core_y_d     = core_y_q;
    core_start_d = 1'b0;
    res_valid_d  = res_valid_q;
    res_phi_d    = res_phi_q;
    res_id_d     = res_id_q;

    case (state_q)
      ST_IDLE: begin
        if (accept0 || accept1) begin
          state_d      = ST_RUN;
          cnt_d        = '0;
          core_start_d = 1'b1;
          id_d         = accept1;
          last_grant_d = accept1;
          core_x_d     = accept1 ? bus.req1_x : bus.req0_x;
          core_y_d     = accept1 ? bus.req1_y : bus.req0_y;
        end
      end
      ST_RUN: begin
        if (capture) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A capture wins over a pop on the same edge: the new result overwrites.
    if (capture) begin
      res_valid_d = 1'b1;
      res_phi_d   = bus.core_phi;
      res_id_d    = id_q;
    end else if (res_valid_q && bus.res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      core_x_q     <= '0;
      core_y_q     <= '0;
      core_start_q <= 1'b0;
      res_valid_q  <= 1'b0;
      res_phi_q    <= '0;
      res_id_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      core_x_q     <= core_x_d;
      core_y_q     <= core_y_d;
      core_start_q <= core_start_d;
      res_valid_q  <= res_valid_d;
      res_phi_q    <= res_phi_d;
      res_id_q     <= res_id_d;
    end
  end

`ifdef CORDIC_SCHED_STATS_EN
  logic [15:0] job_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      job_cnt_q <= 16'h0000;
    end else if (capture && (job_cnt_q != 16'hFFFF)) begin
      job_cnt_q <= job_cnt_q + 16'h0001;
    end
  end

  assign job_cnt = job_cnt_q;
`endif

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_phi    = res_phi_q;
  assign bus.res_id     = res_id_q;
  assign bus.busy       = (state_q == ST_RUN);
  assign bus.core_start = core_start_q;
  assign bus.core_x     = core_x_q;
  assign bus.core_y     = core_y_q;

endmodule
`default_nettype wire

// File: tb/tb_cordic_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_cordic_sched
// Description : Self-checking bench for cordic_sched. A transaction-level
//               reference model (job start cycle, result slot, last winner)
//               predicts every output each cycle; directed phases cover a
//               single job, contention, back-pressure and reset mid-job,
//               followed by a randomized phase.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cordic_sched;
  localparam int W   = 32;
  localparam int LAT = 28;

  logic clk = 1'b0;
  logic rst = 1'b1;

  cordic_sched_if #(.W(W)) bus ();
`ifdef CORDIC_SCHED_STATS_EN
  logic [15:0] job_cnt;
`endif

  cordic_sched #(.W(W), .CORE_LAT(LAT)) dut (
    .clk     (clk),
    .rst     (rst),
`ifdef CORDIC_SCHED_STATS_EN
    .job_cnt (job_cnt),
`endif
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int cyc    = 0;
  int n_cmp  = 0;
  int n_bad  = 0;
  logic chk_on = 1'b0;
  logic fixed_phi = 1'b0;
  int phase  = 0;
  int ids[$];

  task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    chk_on <= 1'b1;
  end

  // Reference model: a job accepted at the end of cycle A runs in cycles
  // A+1 .. A+1+LAT and its phase is taken from core_phi in the last of them.
  int           m_start = -1000;
  logic         m_last  = 1'b1;
  logic         m_full  = 1'b0;
  logic [W-1:0] m_phi   = '0;
  logic         m_rid   = 1'b0;
  logic         m_id    = 1'b0;
  logic [W-1:0] m_x     = '0;
  logic [W-1:0] m_y     = '0;
  int           m_jobs  = 0;

  always @(negedge clk) begin : model
    logic in_run, free, any, win, e_r0, e_r1, cap;
    in_run = (cyc >= m_start) && (cyc <= m_start + LAT);
    free   = !m_full || bus.res_ready;
    any    = bus.req0_valid || bus.req1_valid;
    if (bus.req0_valid && bus.req1_valid) win = ~m_last;
    else                                  win = bus.req1_valid;
    e_r0 = !rst && !in_run && free && any && (win == 1'b0);
    e_r1 = !rst && !in_run && free && any && (win == 1'b1);

    if (chk_on) begin
      chk_eq("req0_ready", bus.req0_ready, e_r0);
      chk_eq("req1_ready", bus.req1_ready, e_r1);
      chk_eq("busy",       bus.busy, in_run);
      chk_eq("core_start", bus.core_start, in_run && (cyc == m_start));
      chk_eq("core_x",     bus.core_x, m_x);
      chk_eq("core_y",     bus.core_y, m_y);
      chk_eq("res_valid",  bus.res_valid, m_full);
      chk_eq("res_phi",    bus.res_phi, m_phi);
      chk_eq("res_id",     bus.res_id, m_rid);
`ifdef CORDIC_SCHED_STATS_EN
      chk_eq("job_cnt",    job_cnt, m_jobs[15:0]);
`endif
      if (phase == 2 && bus.res_valid && bus.res_ready) ids.push_back(int'(bus.res_id));
    end

    if (rst) begin
      m_start = -1000;
      m_last  = 1'b1;
      m_full  = 1'b0;
      m_phi   = '0;
      m_rid   = 1'b0;
      m_id    = 1'b0;
      m_x     = '0;
      m_y     = '0;
      m_jobs  = 0;
    end else begin
      cap = in_run && (cyc == m_start + LAT);
      if (cap) begin
        m_full = 1'b1;
        m_phi  = bus.core_phi;
        m_rid  = m_id;
        if (m_jobs < 65535) m_jobs++;
      end else if (m_full && bus.res_ready) begin
        m_full = 1'b0;
      end
      if (e_r0 || e_r1) begin
        m_id    = e_r1;
        m_last  = e_r1;
        m_x     = e_r1 ? bus.req1_x : bus.req0_x;
        m_y     = e_r1 ? bus.req1_y : bus.req0_y;
        m_start = cyc + 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (!fixed_phi) bus.core_phi = $urandom;
  endtask

  initial begin
    repeat (50000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.req0_valid = 1'b0; bus.req0_x = '0; bus.req0_y = '0;
    bus.req1_valid = 1'b0; bus.req1_x = '0; bus.req1_y = '0;
    bus.res_ready  = 1'b1; bus.core_phi = '0;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;

    // Single job from req0 with a constant core result.
    phase = 1;
    fixed_phi = 1'b1;
    bus.core_phi   = 32'h0000_C90F;
    bus.req0_x     = 32'h0001_0000;
    bus.req0_y     = 32'h0001_0000;
    bus.req0_valid = 1'b1;
    tick();
    bus.req0_valid = 1'b0;
    bus.req0_x     = $urandom;          // operands must stay latched
    chk_eq("single_start", bus.core_start, 1'b1);
    repeat (LAT + 1) tick();
    chk_eq("single_valid", bus.res_valid, 1'b1);
    chk_eq("single_phi",   bus.res_phi, 32'h0000_C90F);
    chk_eq("single_id",    bus.res_id, 1'b0);
    fixed_phi = 1'b0;
    tick();

    // Contention from a fresh reset: grants alternate starting with req0.
    rst = 1'b1; tick(); rst = 1'b0;
    phase = 2;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    repeat (4 * (LAT + 2) + 4) begin
      tick();
      bus.req0_x = $urandom; bus.req0_y = $urandom;
      bus.req1_x = $urandom; bus.req1_y = $urandom;
    end
    phase = 3;
    chk_eq("contend_count", 64'(ids.size() >= 4), 64'd1);
    if (ids.size() >= 4) begin
      chk_eq("contend_id0", 64'(ids[0]), 64'd0);
      chk_eq("contend_id1", 64'(ids[1]), 64'd1);
      chk_eq("contend_id2", 64'(ids[2]), 64'd0);
      chk_eq("contend_id3", 64'(ids[3]), 64'd1);
    end

    // Back-pressure: held result blocks all grants until popped.
    bus.res_ready = 1'b0;
    repeat (3 * (LAT + 2)) tick();
    chk_eq("bp_hold_valid", bus.res_valid, 1'b1);
    chk_eq("bp_no_grant",   {bus.req0_ready, bus.req1_ready}, 2'b00);
    bus.res_ready = 1'b1;
    #1;
    chk_eq("bp_pop_grant",  bus.req0_ready | bus.req1_ready, 1'b1);
    tick();
    chk_eq("bp_after_busy",  bus.busy, 1'b1);
    chk_eq("bp_after_empty", bus.res_valid, 1'b0);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    repeat (LAT + 4) tick();

    // Reset while the core counter is at 10.
    bus.req0_valid = 1'b1;
    tick();
    bus.req0_valid = 1'b0;
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_eq("rst_busy",  bus.busy, 1'b0);
    chk_eq("rst_valid", bus.res_valid, 1'b0);
    bus.req1_x = $urandom;
    bus.req1_valid = 1'b1;
    tick();
    bus.req1_valid = 1'b0;
    repeat (LAT + 1) tick();
    chk_eq("post_rst_valid", bus.res_valid, 1'b1);
    chk_eq("post_rst_id",    bus.res_id, 1'b1);

    // Randomized traffic with occasional resets.
    phase = 4;
    repeat (3000) begin
      tick();
      bus.req0_valid = ($urandom_range(0, 3) != 0);
      bus.req1_valid = ($urandom_range(0, 3) != 0);
      bus.req0_x = $urandom; bus.req0_y = $urandom;
      bus.req1_x = $urandom; bus.req1_y = $urandom;
      bus.res_ready  = ($urandom_range(0, 9) < 7);
      rst = ($urandom_range(0, 299) == 0);
    end
    rst = 1'b0;
    tick();
    @(negedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
